led_blink_array: RTL

Multi-channel successor to the single free-running blink counter. It drives N_CH LEDs from one shared prescaler. Each channel has a runtime-selectable mode (off, on, blink, dim), and blink channels have a programmable half-period. A valid/ready config port lets a host FSM or UART command decoder reprogram channels. It sits at top level between CLK and the board LED pins.

---
 rtl/led_blink_pkg.sv | 16 +
 rtl/led_blink_array_if.sv | 34 +++
 rtl/led_blink_chan.sv | 92 +++++++++
 rtl/led_blink_array.sv | 80 ++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
// Mode encoding matches the 2-bit cfg_mode field of the config port.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_e;

    localparam int   PWM_W       = 8;
    localparam int   CHAN_W      = 4;
    localparam logic RESET_STATE = 1'b1;

endpackage

// File: rtl/led_blink_array_if.sv
// Valid/ready config write port used by a host FSM or command decoder
// to reprogram one LED channel per accepted write.
interface led_blink_array_if
    import led_blink_pkg::*;
#(
    parameter int PW = 16
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [1:0]        cfg_mode;
    logic [PW-1:0]     cfg_half;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_mode,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_mode,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: mode/half/phase/state registers plus the output flop.
// A write always restarts the channel lit with phase 0, even on a tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int PW           = 16,
    parameter int DEFAULT_HALF = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    input  logic             we_i,
    input  mode_e            mode_i,
    input  logic [PW-1:0]    half_i,
    output logic             led_o
);

    mode_e         mode_q, mode_d;
    logic [PW-1:0] half_q, half_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          state_q, state_d;
    logic          led_q, led_d;
    logic [PW-1:0] phase_last;

    // half=0 is treated as half=1, so the last phase is 0 in both cases.
    assign phase_last = (half_q == '0) ? '0 : half_q - PW'(1);

    // NOTE: every _d gets a default before the branches; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        mode_d  = mode_q;
        half_d  = half_q;
        phase_d = phase_q;
        state_d = state_q;
        led_d   = state_q ^ ACTIVE_LOW;

        if (we_i) begin
            mode_d  = mode_i;
            half_d  = half_i;
            phase_d = '0;
            state_d = RESET_STATE;
        end else begin
            unique case (mode_q)
                MODE_OFF: begin
                    phase_d = '0;
                    state_d = 1'b0;
                end
                MODE_ON: begin
                    phase_d = '0;
                    state_d = 1'b1;
                end
                MODE_BLINK: begin
                    if (tick_i) begin
                        if (phase_q == phase_last) begin
                            phase_d = '0;
                            state_d = ~state_q;
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end
                end
                MODE_DIM: begin
                    phase_d = '0;
                    state_d = (pwm_cnt_i < half_q[PWM_W-1:0]);
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_BLINK;
            half_q  <= PW'(DEFAULT_HALF);
            phase_q <= '0;
            state_q <= RESET_STATE;
            led_q   <= RESET_STATE ^ ACTIVE_LOW;
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            state_q <= state_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_blink_array.sv
// N_CH-channel LED driver with a shared tick prescaler and PWM counter.
// Owns the config handshake, channel address decode and error pulse.
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int PRESCALE     = 36000,
    parameter int PW           = 16,
    parameter int DEFAULT_HALF = 500,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    led_blink_array_if.slave  cfg,
    output logic [N_CH-1:0]   LED
);

    localparam int              PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             accept;
    logic             chan_ok;
    logic [N_CH-1:0]  we;

    assign accept  = cfg.cfg_valid && ready_q;
    assign chan_ok = ({1'b0, cfg.cfg_chan} < (CHAN_W + 1)'(N_CH));

    always_comb begin
        presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
        tick_d  = (presc_q == PS_LAST);
        pwm_d   = pwm_q + PWM_W'(1);
        ready_d = 1'b1;
        err_d   = accept && !chan_ok;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    // Out-of-range indices match no channel, so such writes touch nothing.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        assign we[i] = accept && (cfg.cfg_chan == CHAN_W'(i));

        led_blink_chan #(
            .PW           (PW),
            .DEFAULT_HALF (DEFAULT_HALF),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk_i     (CLK),
            .rst_i     (RST),
            .tick_i    (tick_q),
            .pwm_cnt_i (pwm_q),
            .we_i      (we[i]),
            .mode_i    (mode_e'(cfg.cfg_mode)),
            .half_i    (cfg.cfg_half),
            .led_o     (LED[i])
        );
    end

endmodule
